// File: rtl/ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ctrl_pkg : shared control-bundle types and encodings for ctrl_pipe |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package ctrl_pkg;

  localparam int CTRL_REG_ADDR_W = 5;
  localparam int CTRL_ALUOP_W    = 2;

  localparam logic [CTRL_ALUOP_W-1:0] ALUOP_LDST = 2'b00;
  localparam logic [CTRL_ALUOP_W-1:0] ALUOP_BEQ  = 2'b01;
  localparam logic [CTRL_ALUOP_W-1:0] ALUOP_R    = 2'b10;
  localparam logic [CTRL_ALUOP_W-1:0] ALUOP_IMM  = 2'b11;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  typedef struct packed {
    logic                       valid;
    logic [CTRL_ALUOP_W-1:0]    alu_op;
    logic                       alu_src;
    logic                       reg_write;
    logic                       mem_write;
    logic                       mem_read;
    logic                       mem2reg;
    logic [CTRL_REG_ADDR_W-1:0] rs1;
    logic [CTRL_REG_ADDR_W-1:0] rs2;
    logic [CTRL_REG_ADDR_W-1:0] rd;
  } ctrl_bundle_t;

  typedef struct packed {
    logic                       reg_write;
    logic                       mem_write;
    logic                       mem_read;
    logic                       mem2reg;
    logic [CTRL_REG_ADDR_W-1:0] rd;
  } mem_bundle_t;

  typedef struct packed {
    logic                       reg_write;
    logic                       mem2reg;
    logic [CTRL_REG_ADDR_W-1:0] rd;
  } wb_bundle_t;

  localparam ctrl_bundle_t BUBBLE = '0;

endpackage
`default_nettype wire

// File: rtl/hazard_fwd_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hazard_fwd_unit : load-use stall detect and EX operand forwarding  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module hazard_fwd_unit
  import ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = CTRL_REG_ADDR_W
) (
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  ex_valid,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [REG_ADDR_W-1:0] ex_rs1,
  input  logic [REG_ADDR_W-1:0] ex_rs2,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  wb_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  stall,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b
);

  // The younger EX/MEM result shadows MEM/WB; x0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] rs,
    input logic                  m_rw,
    input logic [REG_ADDR_W-1:0] m_rd,
    input logic                  w_rw,
    input logic [REG_ADDR_W-1:0] w_rd
  );
    if (m_rw && (m_rd != '0) && (m_rd == rs))
      return FWD_MEM;
    else if (w_rw && (w_rd != '0) && (w_rd == rs))
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

  logic w_ex_load;

  assign w_ex_load = ex_valid & ex_mem_read & (ex_rd != '0);
  assign stall     = id_valid & w_ex_load & ((ex_rd == id_rs1) | (ex_rd == id_rs2));
  assign fwd_a     = fwd_sel(ex_rs1, mem_reg_write, mem_rd, wb_reg_write, wb_rd);
  assign fwd_b     = fwd_sel(ex_rs2, mem_reg_write, mem_rd, wb_reg_write, wb_rd);

endmodule
`default_nettype wire

// File: rtl/ctrl_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ctrl_pipe : ID/EX, EX/MEM, MEM/WB control registers with bubbles   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = CTRL_REG_ADDR_W,
  parameter int ALUOP_W    = CTRL_ALUOP_W,
  parameter int CNT_W      = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  id_valid_i,
  input  logic [ALUOP_W-1:0]    id_ALUOp_i,
  input  logic                  id_ALUSrc_i,
  input  logic                  id_RegWrite_i,
  input  logic                  id_MemWrite_i,
  input  logic                  id_MemRead_i,
  input  logic                  id_Mem2Reg_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic                  flush_i,
  output logic                  stall_o,
  output logic [ALUOP_W-1:0]    ex_ALUOp_o,
  output logic                  ex_ALUSrc_o,
  output logic [1:0]            fwdA_o,
  output logic [1:0]            fwdB_o,
  output logic                  mem_MemWrite_o,
  output logic                  mem_MemRead_o,
  output logic [REG_ADDR_W-1:0] mem_rd_o,
  output logic                  wb_RegWrite_o,
  output logic                  wb_Mem2Reg_o,
  output logic [REG_ADDR_W-1:0] wb_rd_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o
);

  ctrl_bundle_t     r_id_ex;
  mem_bundle_t      r_ex_mem;
  wb_bundle_t       r_mem_wb;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  ctrl_bundle_t     w_id_bundle;
  logic             w_stall;
  logic             w_take;

  assign w_id_bundle = '{
    valid:     1'b1,
    alu_op:    id_ALUOp_i,
    alu_src:   id_ALUSrc_i,
    reg_write: id_RegWrite_i,
    mem_write: id_MemWrite_i,
    mem_read:  id_MemRead_i,
    mem2reg:   id_Mem2Reg_i,
    rs1:       id_rs1_i,
    rs2:       id_rs2_i,
    rd:        id_rd_i
  };

  // Stall, flush and empty ID all collapse to a bubble; flush needs no extra cycle.
  assign w_take = id_valid_i & ~w_stall & ~flush_i;

  hazard_fwd_unit #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_hazard_fwd (
    .id_valid      (id_valid_i),
    .id_rs1        (id_rs1_i),
    .id_rs2        (id_rs2_i),
    .ex_valid      (r_id_ex.valid),
    .ex_mem_read   (r_id_ex.mem_read),
    .ex_rd         (r_id_ex.rd),
    .ex_rs1        (r_id_ex.rs1),
    .ex_rs2        (r_id_ex.rs2),
    .mem_reg_write (r_ex_mem.reg_write),
    .mem_rd        (r_ex_mem.rd),
    .wb_reg_write  (r_mem_wb.reg_write),
    .wb_rd         (r_mem_wb.rd),
    .stall         (w_stall),
    .fwd_a         (fwdA_o),
    .fwd_b         (fwdB_o)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_id_ex     <= BUBBLE;
      r_ex_mem    <= '0;
      r_mem_wb    <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_id_ex  <= w_take ? w_id_bundle : BUBBLE;
      r_ex_mem <= '{
        reg_write: r_id_ex.reg_write,
        mem_write: r_id_ex.mem_write,
        mem_read:  r_id_ex.mem_read,
        mem2reg:   r_id_ex.mem2reg,
        rd:        r_id_ex.rd
      };
      r_mem_wb <= '{
        reg_write: r_ex_mem.reg_write,
        mem2reg:   r_ex_mem.mem2reg,
        rd:        r_ex_mem.rd
      };
      if (w_stall && !(&r_stall_cnt))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (flush_i && !(&r_flush_cnt))
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign stall_o        = w_stall;
  assign ex_ALUOp_o     = r_id_ex.alu_op;
  assign ex_ALUSrc_o    = r_id_ex.alu_src;
  assign mem_MemWrite_o = r_ex_mem.mem_write;
  assign mem_MemRead_o  = r_ex_mem.mem_read;
  assign mem_rd_o       = r_ex_mem.rd;
  assign wb_RegWrite_o  = r_mem_wb.reg_write;
  assign wb_Mem2Reg_o   = r_mem_wb.mem2reg;
  assign wb_rd_o        = r_mem_wb.rd;
  assign stall_cnt_o    = r_stall_cnt;
  assign flush_cnt_o    = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_ctrl_pipe : self-checking bench for ctrl_pipe                   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_ctrl_pipe;

  localparam int CW      = 5;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          id_valid_i, id_ALUSrc_i, id_RegWrite_i, id_MemWrite_i, id_MemRead_i, id_Mem2Reg_i;
  logic [1:0]    id_ALUOp_i;
  logic [4:0]    id_rs1_i, id_rs2_i, id_rd_i;
  logic          flush_i;
  logic          stall_o, ex_ALUSrc_o, mem_MemWrite_o, mem_MemRead_o, wb_RegWrite_o, wb_Mem2Reg_o;
  logic [1:0]    ex_ALUOp_o, fwdA_o, fwdB_o;
  logic [4:0]    mem_rd_o, wb_rd_o;
  logic [CW-1:0] stall_cnt_o, flush_cnt_o;

  always #5 clk_i = ~clk_i;

  ctrl_pipe #(.REG_ADDR_W(5), .ALUOP_W(2), .CNT_W(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i), .id_ALUOp_i(id_ALUOp_i),
    .id_ALUSrc_i(id_ALUSrc_i), .id_RegWrite_i(id_RegWrite_i), .id_MemWrite_i(id_MemWrite_i),
    .id_MemRead_i(id_MemRead_i), .id_Mem2Reg_i(id_Mem2Reg_i), .id_rs1_i(id_rs1_i),
    .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i), .flush_i(flush_i), .stall_o(stall_o),
    .ex_ALUOp_o(ex_ALUOp_o), .ex_ALUSrc_o(ex_ALUSrc_o), .fwdA_o(fwdA_o), .fwdB_o(fwdB_o),
    .mem_MemWrite_o(mem_MemWrite_o), .mem_MemRead_o(mem_MemRead_o), .mem_rd_o(mem_rd_o),
    .wb_RegWrite_o(wb_RegWrite_o), .wb_Mem2Reg_o(wb_Mem2Reg_o), .wb_rd_o(wb_rd_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  typedef struct {
    bit       v;
    bit [1:0] op;
    bit       src, rw, mw, mr, m2r;
    bit [4:0] rs1, rs2, rd;
  } ins_t;

  // Reference model: the instruction presented to ID plus a 3-deep history of
  // what entered EX (index 0 = EX, 1 = MEM, 2 = WB).
  ins_t cur;
  bit   fl;
  ins_t pipe [3];
  int   m_stall_cnt, m_flush_cnt;
  int   errors = 0;
  int   checks = 0;

  assign id_valid_i    = cur.v;
  assign id_ALUOp_i    = cur.op;
  assign id_ALUSrc_i   = cur.src;
  assign id_RegWrite_i = cur.rw;
  assign id_MemWrite_i = cur.mw;
  assign id_MemRead_i  = cur.mr;
  assign id_Mem2Reg_i  = cur.m2r;
  assign id_rs1_i      = cur.rs1;
  assign id_rs2_i      = cur.rs2;
  assign id_rd_i       = cur.rd;
  assign flush_i       = fl;

  function automatic ins_t nop_i();
    ins_t b = '{default: 0};
    return b;
  endfunction

  function automatic ins_t mk(bit [1:0] op, bit src, bit rw, bit mw, bit mr, bit m2r,
                              bit [4:0] rs1, bit [4:0] rs2, bit [4:0] rd);
    ins_t b;
    b.v = 1'b1; b.op = op; b.src = src; b.rw = rw; b.mw = mw; b.mr = mr; b.m2r = m2r;
    b.rs1 = rs1; b.rs2 = rs2; b.rd = rd;
    return b;
  endfunction

  function automatic ins_t lw(bit [4:0] rd, bit [4:0] base);
    return mk(2'b00, 1, 1, 0, 1, 1, base, 5'd0, rd);
  endfunction

  function automatic ins_t radd(bit [4:0] rd, bit [4:0] a, bit [4:0] b);
    return mk(2'b10, 0, 1, 0, 0, 0, a, b, rd);
  endfunction

  function automatic ins_t rand_ins();
    ins_t b;
    b.v   = ($urandom_range(3) != 0);
    b.op  = 2'($urandom_range(3));
    b.src = 1'($urandom_range(1));
    b.rw  = 1'($urandom_range(1));
    b.mw  = 1'($urandom_range(1));
    b.mr  = 1'($urandom_range(1));
    b.m2r = 1'($urandom_range(1));
    b.rs1 = 5'($urandom_range(3));
    b.rs2 = 5'($urandom_range(3));
    b.rd  = 5'($urandom_range(3));
    return b;
  endfunction

  function automatic bit m_stall();
    return cur.v && pipe[0].mr && (pipe[0].rd != 0) &&
           ((pipe[0].rd == cur.rs1) || (pipe[0].rd == cur.rs2));
  endfunction

  function automatic bit [1:0] m_fwd(bit [4:0] rs);
    if (pipe[1].rw && pipe[1].rd != 0 && pipe[1].rd == rs) return 2'b10;
    if (pipe[2].rw && pipe[2].rd != 0 && pipe[2].rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] exp_vec();
    return {m_stall(), pipe[0].op, pipe[0].src, m_fwd(pipe[0].rs1), m_fwd(pipe[0].rs2),
            pipe[1].mw, pipe[1].mr, pipe[1].rd, pipe[2].rw, pipe[2].m2r, pipe[2].rd,
            CW'(m_stall_cnt), CW'(m_flush_cnt)};
  endfunction

  function automatic logic [31:0] dut_vec();
    return {stall_o, ex_ALUOp_o, ex_ALUSrc_o, fwdA_o, fwdB_o, mem_MemWrite_o, mem_MemRead_o,
            mem_rd_o, wb_RegWrite_o, wb_Mem2Reg_o, wb_rd_o, stall_cnt_o, flush_cnt_o};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) pipe[i] = nop_i();
    m_stall_cnt = 0;
    m_flush_cnt = 0;
  endtask

  task automatic drive(ins_t b, bit f);
    cur = b;
    fl  = f;
    #1;
  endtask

  task automatic tick();
    bit s;
    s = m_stall();
    @(posedge clk_i);
    if (s && m_stall_cnt < CNT_MAX) m_stall_cnt++;
    if (fl && m_flush_cnt < CNT_MAX) m_flush_cnt++;
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = (cur.v && !s && !fl) ? cur : nop_i();
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) begin
      drive(nop_i(), 0);
      tick();
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    drive(nop_i(), 0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_vec() !== 32'h0) begin
      errors++; $display("FAIL reset_state: got %h want 00000000", dut_vec());
    end
    for (int i = 0; i < 4; i++) begin
      drive(mk(2'b10, 1, 1, 1, 1, 1, 5'd3, 5'd4, 5'(i + 1)), 0);
      tick();
    end
    rst_i = 1'b1;
    #1;
    checks++;
    if (dut_vec() !== 32'h0) begin
      errors++; $display("FAIL async_reset_midflight: got %h want 00000000", dut_vec());
    end
    rst_i = 1'b0;
    model_reset();
    drive(radd(5'd9, 5'd1, 5'd2), 0);
    tick();
    drive(nop_i(), 0);
    tick();
    checks++;
    if (wb_RegWrite_o !== 1'b0 || wb_rd_o !== 5'd0) begin
      errors++; $display("FAIL wb_early: got rw=%b rd=%0d want rw=0 rd=0", wb_RegWrite_o, wb_rd_o);
    end
    tick();
    checks++;
    if (wb_RegWrite_o !== 1'b1 || wb_rd_o !== 5'd9) begin
      errors++; $display("FAIL wb_latency3: got rw=%b rd=%0d want rw=1 rd=9", wb_RegWrite_o, wb_rd_o);
    end
  endtask

  task automatic test_load_use();
    int c0;
    drain();
    c0 = m_stall_cnt;
    drive(lw(5'd5, 5'd1), 0);
    tick();
    drive(radd(5'd6, 5'd5, 5'd7), 0);
    checks++;
    if (stall_o !== 1'b1) begin
      errors++; $display("FAIL load_use_stall: got %b want 1", stall_o);
    end
    tick();
    checks++;
    if (stall_o !== 1'b0 || ex_ALUOp_o !== 2'b00 || ex_ALUSrc_o !== 1'b0) begin
      errors++; $display("FAIL load_use_bubble: got stall=%b op=%b src=%b want 0 00 0",
                         stall_o, ex_ALUOp_o, ex_ALUSrc_o);
    end
    tick();
    drive(nop_i(), 0);
    checks++;
    if (fwdA_o !== 2'b01 || fwdB_o !== 2'b00 || ex_ALUOp_o !== 2'b10) begin
      errors++; $display("FAIL load_use_fwd: got fwdA=%b fwdB=%b op=%b want 01 00 10",
                         fwdA_o, fwdB_o, ex_ALUOp_o);
    end
    checks++;
    if (stall_cnt_o !== CW'(c0 + 1)) begin
      errors++; $display("FAIL load_use_cnt: got %0d want %0d", stall_cnt_o, c0 + 1);
    end
  endtask

  task automatic test_forward();
    drain();
    drive(radd(5'd5, 5'd1, 5'd2), 0);
    tick();
    drive(mk(2'b10, 0, 1, 0, 0, 0, 5'd5, 5'd5, 5'd8), 0);
    checks++;
    if (stall_o !== 1'b0) begin
      errors++; $display("FAIL fwd_mem_nostall: got %b want 0", stall_o);
    end
    tick();
    drive(nop_i(), 0);
    checks++;
    if (fwdA_o !== 2'b10 || fwdB_o !== 2'b10) begin
      errors++; $display("FAIL fwd_mem: got %b %b want 10 10", fwdA_o, fwdB_o);
    end
    drain();
    drive(radd(5'd5, 5'd1, 5'd2), 0);
    tick();
    drive(radd(5'd9, 5'd1, 5'd2), 0);
    tick();
    drive(mk(2'b10, 0, 1, 0, 0, 0, 5'd5, 5'd5, 5'd8), 0);
    tick();
    drive(nop_i(), 0);
    checks++;
    if (fwdA_o !== 2'b01 || fwdB_o !== 2'b01) begin
      errors++; $display("FAIL fwd_wb: got %b %b want 01 01", fwdA_o, fwdB_o);
    end
  endtask

  task automatic test_flush();
    int f0;
    drain();
    f0 = m_flush_cnt;
    drive(lw(5'd5, 5'd1), 0);
    tick();
    drive(mk(2'b00, 1, 0, 1, 0, 0, 5'd2, 5'd5, 5'd0), 1);
    checks++;
    if (stall_o !== 1'b1) begin
      errors++; $display("FAIL flush_hazard_seen: got %b want 1", stall_o);
    end
    tick();
    drive(nop_i(), 0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mem_MemWrite_o !== 1'b0) begin
        errors++; $display("FAIL flush_no_store: cycle %0d got %b want 0", i, mem_MemWrite_o);
      end
      tick();
    end
    checks++;
    if (flush_cnt_o !== CW'(f0 + 1)) begin
      errors++; $display("FAIL flush_cnt: got %0d want %0d", flush_cnt_o, f0 + 1);
    end
  endtask

  task automatic test_x0();
    drain();
    drive(lw(5'd0, 5'd1), 0);
    tick();
    drive(radd(5'd3, 5'd0, 5'd0), 0);
    checks++;
    if (stall_o !== 1'b0) begin
      errors++; $display("FAIL x0_nostall: got %b want 0", stall_o);
    end
    tick();
    drive(nop_i(), 0);
    checks++;
    if (fwdA_o !== 2'b00 || fwdB_o !== 2'b00) begin
      errors++; $display("FAIL x0_nofwd: got %b %b want 00 00", fwdA_o, fwdB_o);
    end
    tick();
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL x0_state: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    ins_t b;
    bit   f, s;
    b = rand_ins();
    for (int i = 0; i < 300; i++) begin
      f = ($urandom_range(7) == 0);
      drive(b, f);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL random cycle %0d: got %h want %h", i, dut_vec(), exp_vec());
      end
      s = m_stall();
      tick();
      if (!(s && !f)) b = rand_ins();
    end
  endtask

  task automatic test_saturation();
    rst_i = 1'b1;
    #1;
    rst_i = 1'b0;
    model_reset();
    for (int i = 0; i < CNT_MAX + 3; i++) begin
      drive(lw(5'd5, 5'd1), 0);
      tick();
      drive(radd(5'd6, 5'd5, 5'd7), 0);
      tick();
      tick();
    end
    checks++;
    if (stall_cnt_o !== CW'(CNT_MAX)) begin
      errors++; $display("FAIL stall_cnt_sat: got %0d want %0d", stall_cnt_o, CNT_MAX);
    end
    drive(lw(5'd5, 5'd1), 0);
    tick();
    drive(radd(5'd6, 5'd5, 5'd7), 0);
    checks++;
    if (stall_o !== 1'b1) begin
      errors++; $display("FAIL sat_stall_again: got %b want 1", stall_o);
    end
    tick();
    checks++;
    if (stall_cnt_o !== CW'(CNT_MAX)) begin
      errors++; $display("FAIL stall_cnt_hold: got %0d want %0d", stall_cnt_o, CNT_MAX);
    end
    for (int i = 0; i < CNT_MAX + 4; i++) begin
      drive(nop_i(), 1);
      tick();
    end
    drive(nop_i(), 0);
    checks++;
    if (flush_cnt_o !== CW'(CNT_MAX)) begin
      errors++; $display("FAIL flush_cnt_hold: got %0d want %0d", flush_cnt_o, CNT_MAX);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    cur   = nop_i();
    fl    = 1'b0;
    model_reset();
    test_reset();
    test_load_use();
    test_forward();
    test_flush();
    test_x0();
    test_random();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
